// File: rtl/memory_access_controller.sv
// rtl/memory_access_controller.sv - Moore FSM sequencing MAR/MDR loads and memory strobes per access.
// Optional wait-state timeout enabled by defining MEM_TIMEOUT_EN (default build: unbounded wait, error = 0).
module memory_access_controller #(
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic clk,
    input  logic clr,
    input  logic start,
    input  logic rw,
    input  logic mem_ready,
    output logic MAR_enable,
    output logic MDR_read,
    output logic MDR_enable,
    output logic mem_read,
    output logic mem_write,
    output logic busy,
    output logic done,
    output logic error
);

`ifdef MEM_TIMEOUT_EN
    localparam bit TIMEOUT_EN = 1'b1;
`else
    localparam bit TIMEOUT_EN = 1'b0;
`endif

    // Counter holds (wait cycle - 1), so the last permitted wait cycle sees TIMEOUT_CYCLES-1.
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE, ADDR, RD_WAIT, RD_LATCH, WR_LOAD, WR_WAIT, DONE, ERR
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       rw_q, rw_d;
    logic       waiting;

    logic mar_en_q, mar_en_d;
    logic mdr_rd_q, mdr_rd_d;
    logic mdr_en_q, mdr_en_d;
    logic mem_rd_q, mem_rd_d;
    logic mem_wr_q, mem_wr_d;
    logic busy_q, busy_d;
    logic done_q, done_d;
    logic error_q, error_d;

    assign waiting = (state_q == RD_WAIT) || (state_q == WR_WAIT);

    always_comb begin
        state_d = state_q;
        rw_d    = rw_q;
        cnt_d   = cnt_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    rw_d    = rw;
                    state_d = ADDR;
                end
            end
            ADDR:     state_d = rw_q ? WR_LOAD : RD_WAIT;
            RD_WAIT: begin
                if (mem_ready)
                    state_d = RD_LATCH;
                else if (TIMEOUT_EN && (cnt_q >= TO_LAST))
                    state_d = ERR;
            end
            RD_LATCH: state_d = DONE;
            WR_LOAD:  state_d = WR_WAIT;
            WR_WAIT: begin
                if (mem_ready)
                    state_d = DONE;
                else if (TIMEOUT_EN && (cnt_q >= TO_LAST))
                    state_d = ERR;
            end
            DONE:     state_d = IDLE;
            ERR:      state_d = IDLE;
            default:  state_d = IDLE;
        endcase

        if (((state_d == RD_WAIT) || (state_d == WR_WAIT)) && !waiting)
            cnt_d = 8'd0;
        else if (waiting && (cnt_q != 8'hFF))
            cnt_d = cnt_q + 8'd1;

        // Outputs are decoded from the next state and registered, so they track state_q exactly.
        mar_en_d = (state_d == ADDR);
        mdr_rd_d = (state_d == RD_WAIT) || (state_d == RD_LATCH);
        mdr_en_d = (state_d == RD_LATCH) || (state_d == WR_LOAD);
        mem_rd_d = (state_d == RD_WAIT) || (state_d == RD_LATCH);
        mem_wr_d = (state_d == WR_WAIT);
        busy_d   = (state_d != IDLE);
        done_d   = (state_d == DONE);
        error_d  = TIMEOUT_EN && (state_d == ERR);
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q  <= IDLE;
            cnt_q    <= 8'd0;
            rw_q     <= 1'b0;
            mar_en_q <= 1'b0;
            mdr_rd_q <= 1'b0;
            mdr_en_q <= 1'b0;
            mem_rd_q <= 1'b0;
            mem_wr_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rw_q     <= rw_d;
            mar_en_q <= mar_en_d;
            mdr_rd_q <= mdr_rd_d;
            mdr_en_q <= mdr_en_d;
            mem_rd_q <= mem_rd_d;
            mem_wr_q <= mem_wr_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            error_q  <= error_d;
        end
    end

    assign MAR_enable = mar_en_q;
    assign MDR_read   = mdr_rd_q;
    assign MDR_enable = mdr_en_q;
    assign mem_read   = mem_rd_q;
    assign mem_write  = mem_wr_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign error      = error_q;

endmodule

// File: tb/tb_memory_access_controller.sv
// tb/tb_memory_access_controller.sv - directed self-checking bench for memory_access_controller.
// Output vector order: {MAR_enable, MDR_read, MDR_enable, mem_read, mem_write, busy, done, error}.
module tb_memory_access_controller;

    logic clk;
    logic clr;
    logic start;
    logic rw;
    logic mem_ready;
    logic MAR_enable, MDR_read, MDR_enable, mem_read, mem_write, busy, done, error;

    int checks;
    int failures;

    memory_access_controller #(.TIMEOUT_CYCLES(4)) dut (
        .clk        (clk),
        .clr        (clr),
        .start      (start),
        .rw         (rw),
        .mem_ready  (mem_ready),
        .MAR_enable (MAR_enable),
        .MDR_read   (MDR_read),
        .MDR_enable (MDR_enable),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [7:0] outs();
        return {MAR_enable, MDR_read, MDR_enable, mem_read, mem_write, busy, done, error};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        clr = 1'b0; start = 1'b0; rw = 1'b0; mem_ready = 1'b0;
        #1;
        checks++;
        if (outs() !== 8'h00) begin
            failures++;
            $display("FAIL reset_async outs=%h expected=%h", outs(), 8'h00);
        end
        start = 1'b1; rw = 1'b1; mem_ready = 1'b1;
        step();
        step();
        checks++;
        if (outs() !== 8'h00) begin
            failures++;
            $display("FAIL reset_held outs=%h expected=%h", outs(), 8'h00);
        end
        start = 1'b0; rw = 1'b0; mem_ready = 1'b0;
        clr = 1'b1;
        step();
        checks++;
        if (outs() !== 8'h00) begin
            failures++;
            $display("FAIL reset_idle outs=%h expected=%h", outs(), 8'h00);
        end
    endtask

    task automatic test_read();
        bit         st [5]  = '{1, 0, 0, 0, 0};
        logic [7:0] exp [5] = '{8'h84, 8'h54, 8'h74, 8'h06, 8'h00};
        for (int c = 0; c < 5; c++) begin
            start = st[c]; rw = 1'b0; mem_ready = 1'b1;
            step();
            checks++;
            if (outs() !== exp[c]) begin
                failures++;
                $display("FAIL read cycle=%0d outs=%h expected=%h", c + 1, outs(), exp[c]);
            end
        end
        start = 1'b0;
    endtask

    task automatic test_write_wait();
        bit         st [8]  = '{1, 0, 0, 0, 0, 0, 0, 1};
        bit         rv [8]  = '{1, 0, 1, 0, 0, 1, 0, 0};
        bit         rdy [8] = '{1, 1, 1, 0, 0, 0, 1, 1};
        logic [7:0] exp [8] = '{8'h84, 8'h24, 8'h0C, 8'h0C, 8'h0C, 8'h0C, 8'h06, 8'h00};
        for (int c = 0; c < 8; c++) begin
            start = st[c]; rw = rv[c]; mem_ready = rdy[c];
            step();
            checks++;
            if (outs() !== exp[c]) begin
                failures++;
                $display("FAIL write cycle=%0d outs=%h expected=%h", c + 1, outs(), exp[c]);
            end
        end
        start = 1'b0; rw = 1'b0; mem_ready = 1'b0;
        step();
        checks++;
        if (outs() !== 8'h00) begin
            failures++;
            $display("FAIL write_done_ignores_start outs=%h expected=%h", outs(), 8'h00);
        end
    endtask

    task automatic test_back_to_back();
        bit         rv [10]  = '{0, 1, 1, 1, 1, 1, 0, 0, 0, 0};
        logic [7:0] exp [10] = '{8'h84, 8'h54, 8'h74, 8'h06, 8'h00,
                                 8'h84, 8'h24, 8'h0C, 8'h06, 8'h00};
        for (int c = 0; c < 10; c++) begin
            start = 1'b1; rw = rv[c]; mem_ready = 1'b1;
            step();
            checks++;
            if (outs() !== exp[c]) begin
                failures++;
                $display("FAIL b2b cycle=%0d outs=%h expected=%h", c + 1, outs(), exp[c]);
            end
        end
        start = 1'b0;
        step();
        checks++;
        if (outs() !== 8'h00) begin
            failures++;
            $display("FAIL b2b_drain outs=%h expected=%h", outs(), 8'h00);
        end
    endtask

    task automatic test_reset_mid_access();
        start = 1'b1; rw = 1'b0; mem_ready = 1'b0;
        step();
        start = 1'b0;
        step();
        step();
        checks++;
        if (outs() !== 8'h54) begin
            failures++;
            $display("FAIL midrst_wait outs=%h expected=%h", outs(), 8'h54);
        end
        #2 clr = 1'b0;
        #1;
        checks++;
        if (outs() !== 8'h00) begin
            failures++;
            $display("FAIL midrst_async outs=%h expected=%h", outs(), 8'h00);
        end
        mem_ready = 1'b1;
        step();
        clr = 1'b1;
        step();
        checks++;
        if (outs() !== 8'h00) begin
            failures++;
            $display("FAIL midrst_no_done outs=%h expected=%h", outs(), 8'h00);
        end
        test_read();
    endtask

`ifdef MEM_TIMEOUT_EN
    task automatic test_timeout();
        logic [7:0] exp_err [7] = '{8'h84, 8'h54, 8'h54, 8'h54, 8'h54, 8'h05, 8'h00};
        bit         rdy [8]     = '{0, 0, 0, 0, 0, 1, 1, 1};
        logic [7:0] exp_ok [8]  = '{8'h84, 8'h54, 8'h54, 8'h54, 8'h54, 8'h74, 8'h06, 8'h00};
        for (int c = 0; c < 7; c++) begin
            start = (c == 0); rw = 1'b0; mem_ready = 1'b0;
            step();
            checks++;
            if (outs() !== exp_err[c]) begin
                failures++;
                $display("FAIL timeout_err cycle=%0d outs=%h expected=%h", c + 1, outs(), exp_err[c]);
            end
        end
        for (int c = 0; c < 8; c++) begin
            start = (c == 0); rw = 1'b0; mem_ready = rdy[c];
            step();
            checks++;
            if (outs() !== exp_ok[c]) begin
                failures++;
                $display("FAIL timeout_race cycle=%0d outs=%h expected=%h", c + 1, outs(), exp_ok[c]);
            end
        end
        start = 1'b0;
    endtask
`else
    task automatic test_no_timeout();
        int bad;
        bad = 0;
        start = 1'b1; rw = 1'b0; mem_ready = 1'b0;
        step();
        start = 1'b0;
        step();
        for (int c = 0; c < 300; c++) begin
            if (outs() !== 8'h54) bad++;
            step();
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL long_wait bad_cycles=%0d expected=0", bad);
        end
        mem_ready = 1'b1;
        step();
        checks++;
        if (outs() !== 8'h74) begin
            failures++;
            $display("FAIL long_wait_latch outs=%h expected=%h", outs(), 8'h74);
        end
        step();
        checks++;
        if (outs() !== 8'h06) begin
            failures++;
            $display("FAIL long_wait_done outs=%h expected=%h", outs(), 8'h06);
        end
        step();
        mem_ready = 1'b0;
    endtask
`endif

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_read();
        test_write_wait();
        test_back_to_back();
        test_reset_mid_access();
`ifdef MEM_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/memory_access_controller.md
MEMORY_ACCESS_CONTROLLER -- requirements
Module: memory_access_controller

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 15, SHALL set the maximum wait-state cycles per access; legal range 1..255.
REQ-002 clk  input  1  system clock; all state SHALL change on its rising edge.
REQ-003 clr  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  access request from the control unit; sampled only in IDLE.
REQ-005 rw  input  1  access type, sampled with start: 0 = read, 1 = write.
REQ-006 mem_ready  input  1  memory chip completion strobe; sampled only in RD_WAIT and WR_WAIT.
REQ-007 MAR_enable  output  1  loads the MAR from the bus.
REQ-008 MDR_read  output  1  MDR input mux select: 1 = MDataIn (memory), 0 = BusMuxOut.
REQ-009 MDR_enable  output  1  MDR register load enable.
REQ-010 mem_read / mem_write  output  1 each  memory chip strobes; never both high.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 done  output  1  one-cycle completion pulse.
REQ-013 error  output  1  one-cycle timeout pulse (see Configuration).

Function
REQ-014 The block SHALL be a Moore FSM, with all outputs decoded from the registered state and the wait counter only.
REQ-015 States: IDLE, ADDR, RD_WAIT, RD_LATCH, WR_LOAD, WR_WAIT, DONE, ERR.
REQ-016 IDLE: when start = 1, latch rw and go to ADDR; otherwise stay in IDLE.
REQ-017 ADDR: MAR_enable = 1 for one cycle; next state is RD_WAIT if the latched rw = 0, else WR_LOAD.
REQ-018 RD_WAIT: mem_read = 1 and MDR_read = 1; go to RD_LATCH when mem_ready = 1.
REQ-019 RD_LATCH: mem_read = 1, MDR_read = 1 and MDR_enable = 1 for one cycle; then go to DONE.
REQ-020 WR_LOAD: MDR_read = 0 and MDR_enable = 1 for one cycle; then go to WR_WAIT.
REQ-021 WR_WAIT: mem_write = 1 and MDR_enable = 0; go to DONE when mem_ready = 1.
REQ-022 DONE: done = 1 for one cycle; then go to IDLE; start SHALL be ignored in DONE.
REQ-023 Outputs not listed for a state SHALL be 0; MDR_read defaults to 0.
REQ-024 Latency with mem_ready already high: start at edge N gives done high in cycle N+4 (read) or N+4 (write); each low mem_ready cycle adds one cycle.
REQ-025 start, rw and mem_ready changes while busy (other than in the WAIT exits) SHALL have no effect; a back-to-back start is accepted the cycle after DONE.
REQ-026 The 8-bit wait counter SHALL clear on entry to RD_WAIT/WR_WAIT, increment each cycle while waiting, and saturate at 255.

Reset
REQ-027 clr = 0 SHALL immediately force IDLE, clear the counter and the latched rw, and drive every output to 0, including mid-access.
REQ-028 After clr is released, the first access SHALL be accepted on the first rising edge with start = 1.

Configuration
REQ-029 Macro MEM_TIMEOUT_EN: when defined, if the counter reaches TIMEOUT_CYCLES in RD_WAIT/WR_WAIT with mem_ready = 0, go to ERR (error = 1 for one cycle, no MDR load, no done), then IDLE.
REQ-030 If mem_ready = 1 in the same cycle the counter reaches TIMEOUT_CYCLES, completion SHALL win.
REQ-031 Without MEM_TIMEOUT_EN: ERR is unreachable, error is tied to 0, and the wait is unbounded.

Verification
REQ-032 Read, mem_ready held 1, start = 1 with rw = 0 at cycle 0: MAR_enable in cycle 1, MDR_read = MDR_enable = 1 in cycle 3, done in cycle 4, busy high for cycles 1-4.
REQ-033 Write, mem_ready low for 3 wait cycles: MDR_enable = 1 with MDR_read = 0 once, mem_write high for 4 cycles, one done pulse, and mem_read never high.
REQ-034 start held high continuously: accesses complete back-to-back with exactly one IDLE cycle between each done and the next MAR_enable.
REQ-035 clr pulsed low during RD_WAIT: all outputs 0 asynchronously, no done, and a new read after release completes normally.
REQ-036 With MEM_TIMEOUT_EN and TIMEOUT_CYCLES = 4, mem_ready held 0: error pulses once, there is no done and no MDR_enable in RD_LATCH, and the block returns to IDLE; mem_ready = 1 on the 4th wait cycle gives done instead.
REQ-037 Without MEM_TIMEOUT_EN, mem_ready held 0 for 300 cycles: the block stays in the wait state with error = 0, and completes once mem_ready rises.
